// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, single-outstanding data-memory access FSM with
// timeout, and MEM/WB register feeding write-back.
module memory_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RA_W    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             MemtoRegE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [RA_W-1:0]  WA3E,
    output logic [WIDTH-1:0] ALUResultM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             StallM,
    output logic             mem_err,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [RA_W-1:0]  WA3W
);

    localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_err;
    logic            w_err_next;

    // EX/MEM register
    logic             r_reg_wm;
    logic             r_mem_wm;
    logic             r_memtoreg_m;
    logic [WIDTH-1:0] r_alu_m;
    logic [WIDTH-1:0] r_wdata_m;
    logic [RA_W-1:0]  r_wa3_m;

    // MEM/WB register
    logic             r_regwrite_w;
    logic             r_memtoreg_w;
    logic [WIDTH-1:0] r_alu_w;
    logic [WIDTH-1:0] r_rdata_w;
    logic [RA_W-1:0]  r_wa3_w;

    logic             w_memop;
    logic             w_is_load;
    logic             w_stall;
    logic [WIDTH-1:0] w_rdata_next;

    always_comb begin
        w_memop   = r_mem_wm | r_memtoreg_m;
        // A store that also claims MemtoReg is treated purely as a store.
        w_is_load = r_memtoreg_m & ~r_mem_wm;

        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_stall      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_memop) begin
                    w_state_next = StAccess;
                    w_cnt_next   = '0;
                    w_stall      = 1'b1;
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    w_state_next = StIdle;
                end else if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                    w_err_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    w_stall    = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Only a completing, acknowledged load carries data; timeouts and stores give zero.
        w_rdata_next = (w_is_load && (r_state == StAccess) && mem_ack) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_reg_wm     <= 1'b0;
            r_mem_wm     <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_alu_m      <= '0;
            r_wdata_m    <= '0;
            r_wa3_m      <= '0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_alu_w      <= '0;
            r_rdata_w    <= '0;
            r_wa3_w      <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;

            if (!w_stall) begin
                r_reg_wm     <= RegWE;
                r_mem_wm     <= MemWE;
                r_memtoreg_m <= MemtoRegE;
                r_alu_m      <= ALUResultE;
                r_wdata_m    <= WriteDataE;
                r_wa3_m      <= WA3E;
                r_alu_w      <= r_alu_m;
                r_wa3_w      <= r_wa3_m;
                r_rdata_w    <= w_rdata_next;
            end

            // A stalled edge inserts a bubble into write-back.
            r_regwrite_w <= ~w_stall & r_reg_wm;
            r_memtoreg_w <= ~w_stall & w_is_load;
        end
    end

    assign ALUResultM = r_alu_m;
    assign mem_req    = (r_state == StAccess);
    assign mem_we     = r_mem_wm;
    assign mem_addr   = r_alu_m;
    assign mem_wdata  = r_wdata_m;
    assign StallM     = w_stall;
    assign mem_err    = r_err;
    assign RegWriteW  = r_regwrite_w;
    assign MemtoRegW  = r_memtoreg_w;
    assign ALUOutW    = r_alu_w;
    assign ReadDataW  = r_rdata_w;
    assign WA3W       = r_wa3_w;

endmodule
